// File: rtl/dmem_pkg.sv
// dmem_pkg: shared log entry type and pass-detect constants for dmem_responder
package dmem_pkg;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } log_entry_t;
  localparam logic [31:0] PASS_ADDR = 32'd108;
  localparam logic [31:0] PASS_DATA = 32'hABCDE7D5;
  localparam logic [31:0] DEFAULT_MMIO_BASE = 32'h0000_0400;
endpackage

// File: rtl/store_log_fifo.sv
// store_log_fifo: MMIO store log FIFO with valid/ready drain and overflow pulse
module store_log_fifo import dmem_pkg::*; #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  log_entry_t data_i,
  input  logic       pop_i,
  output log_entry_t head_o,
  output logic       empty_o,
  output logic       overflow_o
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  log_entry_t mem_q [FIFO_DEPTH];
  logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [PW:0] cnt_q, cnt_d;
  logic full, do_push, do_pop;
  always_comb begin
    empty_o = cnt_q == '0;
    full = cnt_q == FULL_CNT;
    do_pop = pop_i && !empty_o;
    // a pop in the same cycle frees the slot, so a full FIFO still accepts
    do_push = push_i && (!full || do_pop);
    overflow_o = push_i && !do_push;
    wr_d = do_push ? wr_q + 1'b1 : wr_q;
    rd_d = do_pop ? rd_q + 1'b1 : rd_q;
    cnt_d = cnt_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    head_o = mem_q[rd_q];
  end
  always_ff @(posedge clk_i) if (do_push) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk_i or negedge rst_ni)
    if (!rst_ni) begin
      wr_q <= '0;
      rd_q <= '0;
      cnt_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
      cnt_q <= cnt_d;
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: word RAM, MMIO store log and sticky status flags for the data port.
// Define DMEM_PASS_DETECT_EN to build the self-check store detector driving done.
module dmem_responder import dmem_pkg::*; #(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_BASE   = DEFAULT_MMIO_BASE,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow,
  output logic        misaligned,
  output logic        done
);
  localparam int AW = $clog2(DEPTH_WORDS);
  logic [31:0] ram_q [DEPTH_WORDS];
  logic [AW-1:0] idx;
  logic is_mmio, aligned, ram_we, log_push, fifo_empty, fifo_ovf;
  logic ovf_q, ovf_d, mis_q, mis_d;
  log_entry_t head;
  always_comb begin
    idx = address[AW+1:2];
    is_mmio = address >= MMIO_BASE;
    aligned = address[1:0] == 2'b00;
    ram_we = mem_write && aligned && !is_mmio;
    log_push = mem_write && aligned && is_mmio;
    read_data = is_mmio ? '0 : ram_q[idx];
    ovf_d = ovf_q || fifo_ovf;
    mis_d = mis_q || (mem_write && !aligned);
    log_valid = !fifo_empty;
    log_addr = head.addr;
    log_data = head.data;
    log_overflow = ovf_q;
    misaligned = mis_q;
  end
  always_ff @(posedge clk) if (ram_we) ram_q[idx] <= write_data;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      ovf_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      mis_q <= mis_d;
    end
  store_log_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i      (clk),
    .rst_ni     (rst),
    .push_i     (log_push),
    .data_i     ('{addr: address, data: write_data}),
    .pop_i      (log_valid && log_ready),
    .head_o     (head),
    .empty_o    (fifo_empty),
    .overflow_o (fifo_ovf)
  );
`ifdef DMEM_PASS_DETECT_EN
  logic done_q, done_d;
  always_comb done_d = done_q || (mem_write && address == PASS_ADDR && write_data == PASS_DATA);
  always_ff @(posedge clk or negedge rst)
    if (!rst) done_q <= 1'b0;
    else done_q <= done_d;
  assign done = done_q;
`else
  assign done = 1'b0;
`endif
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: randomized and directed checks of dmem_responder against a queue/array model
module tb_dmem_responder;
`ifdef DMEM_PASS_DETECT_EN
  localparam bit PASS_EN = 1'b1;
`else
  localparam bit PASS_EN = 1'b0;
`endif
  localparam logic [31:0] BASE = 32'h0000_0400;
  logic clk = 1'b0, rst = 1'b0, mem_write = 1'b0, log_ready = 1'b0;
  logic [31:0] address = '0, write_data = '0;
  logic [31:0] read_data, log_addr, log_data;
  logic log_valid, log_overflow, misaligned, done;
  int errors = 0, checks = 0;
  logic [31:0] m_ram [64];
  bit m_known [64];
  logic [63:0] m_q [$];
  bit m_ovf, m_mis, m_done;

  always #5 clk = ~clk;

  dmem_responder dut (
    .clk(clk), .rst(rst), .mem_write(mem_write), .address(address),
    .write_data(write_data), .read_data(read_data), .log_valid(log_valid),
    .log_ready(log_ready), .log_addr(log_addr), .log_data(log_data),
    .log_overflow(log_overflow), .misaligned(misaligned), .done(done)
  );

  // Advance one clock, applying the store/pop rules to the model first.
  task automatic tick();
    bit pop;
    int n;
    n = m_q.size();
    pop = (n != 0) && log_ready;
    if (mem_write) begin
      if (address[1:0] != 2'b00) m_mis = 1;
      else if (address < BASE) begin
        m_ram[address[7:2]] = write_data;
        m_known[address[7:2]] = 1;
      end else if (n < 4 || pop) m_q.push_back({address, write_data});
      else m_ovf = 1;
      if (PASS_EN && address == 32'd108 && write_data == 32'hABCDE7D5) m_done = 1;
    end
    if (pop) void'(m_q.pop_front());
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    mem_write = 0;
    log_ready = 0;
    rst = 0;
    #2;
    m_q.delete();
    m_ovf = 0; m_mis = 0; m_done = 0;
    rst = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    checks += 4;
    if (log_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", log_valid); end
    if (log_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", log_overflow); end
    if (misaligned !== 1'b0) begin errors++; $display("FAIL reset_mis got=%b exp=0", misaligned); end
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    rst = 1;
    tick();
    checks++;
    if (log_valid !== 1'b0) begin errors++; $display("FAIL post_reset_valid got=%b exp=0", log_valid); end
  endtask

  task automatic test_ram_store();
    address = 32'd8; write_data = 32'h0BAD_F00D; mem_write = 1;
    tick();
    write_data = 32'h1234_5678;
    #1;
    checks++;
    if (read_data !== 32'h0BAD_F00D) begin errors++; $display("FAIL same_cycle_load got=%h exp=0badf00d", read_data); end
    tick();
    mem_write = 0;
    #1;
    checks++;
    if (read_data !== 32'h1234_5678) begin errors++; $display("FAIL next_cycle_load got=%h exp=12345678", read_data); end
    address = 32'd8 + 32'd256;
    #1;
    checks++;
    if (read_data !== 32'h1234_5678) begin errors++; $display("FAIL alias_load got=%h exp=12345678", read_data); end
  endtask

  task automatic test_fifo_overflow();
    logic [31:0] d [5];
    do_reset();
    for (int i = 0; i < 5; i++) begin
      d[i] = $urandom;
      address = BASE + 32'(4 * i); write_data = d[i]; mem_write = 1;
      tick();
    end
    mem_write = 0;
    tick();
    checks += 3;
    if (log_valid !== 1'b1) begin errors++; $display("FAIL ovf_valid got=%b exp=1", log_valid); end
    if ({log_addr, log_data} !== {BASE, d[0]}) begin errors++; $display("FAIL ovf_head got=%h_%h exp=%h_%h", log_addr, log_data, BASE, d[0]); end
    if (log_overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", log_overflow); end
    log_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (log_valid !== 1'b1 || {log_addr, log_data} !== {BASE + 32'(4 * i), d[i]}) begin
        errors++; $display("FAIL drain_%0d got=%b %h_%h exp=1 %h_%h", i, log_valid, log_addr, log_data, BASE + 32'(4 * i), d[i]);
      end
      tick();
    end
    checks++;
    if (log_valid !== 1'b0) begin errors++; $display("FAIL drain_empty got=%b exp=0", log_valid); end
    log_ready = 0;
  endtask

  task automatic test_full_pop_push();
    int pops;
    logic [31:0] dx;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      address = BASE + 32'(16 * i); write_data = $urandom; mem_write = 1;
      tick();
    end
    dx = $urandom;
    address = 32'h420; write_data = dx; log_ready = 1;
    tick();
    mem_write = 0; log_ready = 0;
    #1;
    checks++;
    if (log_overflow !== 1'b0) begin errors++; $display("FAIL full_pop_ovf got=%b exp=0", log_overflow); end
    log_ready = 1;
    pops = 0;
    for (int k = 0; k < 8 && log_valid === 1'b1; k++) begin
      checks++;
      if ({log_addr, log_data} !== m_q[0]) begin errors++; $display("FAIL full_pop_head_%0d got=%h_%h exp=%h", k, log_addr, log_data, m_q[0]); end
      if (pops == 3 && {log_addr, log_data} !== {32'h420, dx}) begin
        errors++; $display("FAIL full_pop_last got=%h_%h exp=00000420_%h", log_addr, log_data, dx);
      end
      pops++;
      tick();
    end
    checks++;
    if (pops != 4) begin errors++; $display("FAIL full_pop_count got=%0d exp=4", pops); end
    log_ready = 0;
  endtask

  task automatic test_misaligned();
    do_reset();
    address = 32'd4; write_data = 32'h5555_AAAA; mem_write = 1;
    tick();
    address = 32'd6; write_data = 32'hFFFF_FFFF;
    tick();
    address = 32'h402;
    tick();
    mem_write = 0; address = 32'd6;
    #1;
    checks += 3;
    if (read_data !== 32'h5555_AAAA) begin errors++; $display("FAIL misaligned_ram got=%h exp=5555aaaa", read_data); end
    if (misaligned !== 1'b1) begin errors++; $display("FAIL misaligned_flag got=%b exp=1", misaligned); end
    if (log_valid !== 1'b0) begin errors++; $display("FAIL misaligned_push got=%b exp=0", log_valid); end
    address = 32'h404;
    #1;
    checks++;
    if (read_data !== 32'h0) begin errors++; $display("FAIL mmio_load got=%h exp=0", read_data); end
  endtask

  task automatic test_done();
    address = 32'd108; write_data = 32'hABCDE7D4; mem_write = 1;
    tick();
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL done_near got=%b exp=0", done); end
    write_data = 32'hABCDE7D5;
    tick();
    checks++;
    if (done !== PASS_EN) begin errors++; $display("FAIL done_set got=%b exp=%b", done, PASS_EN); end
    write_data = 32'h0;
    tick();
    mem_write = 0;
    #1;
    checks += 2;
    if (done !== PASS_EN) begin errors++; $display("FAIL done_sticky got=%b exp=%b", done, PASS_EN); end
    if (read_data !== 32'h0) begin errors++; $display("FAIL done_ram got=%h exp=0", read_data); end
  endtask

  task automatic test_random();
    int kind;
    logic [31:0] exp_rd;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      kind = $urandom_range(0, 19);
      mem_write = $urandom_range(0, 3) != 0;
      write_data = $urandom;
      log_ready = $urandom_range(0, 2) == 0;
      if (kind == 0) address = {22'($urandom), 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
      else if (kind < 10) address = {22'd0, 8'($urandom), 2'b00};
      else if (kind < 19) begin
        address = $urandom & 32'hFFFF_FFFC;
        if (address < BASE) address = address + BASE;
      end else begin
        address = 32'd108; write_data = 32'hABCDE7D5;
      end
      #1;
      if (address >= BASE || m_known[address[7:2]]) begin
        exp_rd = address >= BASE ? 32'h0 : m_ram[address[7:2]];
        checks++;
        if (read_data !== exp_rd) begin errors++; $display("FAIL rnd_load_%0d addr=%h got=%h exp=%h", c, address, read_data, exp_rd); end
      end
      tick();
      checks += 4;
      if (log_valid !== (m_q.size() != 0)) begin errors++; $display("FAIL rnd_valid_%0d got=%b exp=%b", c, log_valid, m_q.size() != 0); end
      else if (m_q.size() != 0 && {log_addr, log_data} !== m_q[0]) begin errors++; $display("FAIL rnd_head_%0d got=%h_%h exp=%h", c, log_addr, log_data, m_q[0]); end
      if (log_overflow !== m_ovf) begin errors++; $display("FAIL rnd_ovf_%0d got=%b exp=%b", c, log_overflow, m_ovf); end
      if (misaligned !== m_mis) begin errors++; $display("FAIL rnd_mis_%0d got=%b exp=%b", c, misaligned, m_mis); end
      if (done !== m_done) begin errors++; $display("FAIL rnd_done_%0d got=%b exp=%b", c, done, m_done); end
    end
    mem_write = 0; log_ready = 0;
  endtask

  task automatic test_async_reset();
    logic [31:0] d;
    do_reset();
    address = 32'd2; mem_write = 1;
    tick();
    address = 32'd108; write_data = 32'hABCDE7D5;
    tick();
    for (int i = 0; i < 5; i++) begin
      address = BASE + 32'(4 * i); write_data = $urandom;
      tick();
    end
    mem_write = 0; log_ready = 1;
    tick();
    #3;
    rst = 0;
    #1;
    checks += 4;
    if (log_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got=%b exp=0", log_valid); end
    if (log_overflow !== 1'b0) begin errors++; $display("FAIL arst_ovf got=%b exp=0", log_overflow); end
    if (misaligned !== 1'b0) begin errors++; $display("FAIL arst_mis got=%b exp=0", misaligned); end
    if (done !== 1'b0) begin errors++; $display("FAIL arst_done got=%b exp=0", done); end
    m_q.delete();
    m_ovf = 0; m_mis = 0; m_done = 0;
    #1;
    rst = 1;
    tick();
    checks++;
    if (log_valid !== 1'b0) begin errors++; $display("FAIL arst_empty got=%b exp=0", log_valid); end
    d = $urandom;
    log_ready = 0; address = 32'h500; write_data = d; mem_write = 1;
    tick();
    mem_write = 0;
    tick();
    checks++;
    if (log_valid !== 1'b1 || {log_addr, log_data} !== {32'h500, d}) begin
      errors++; $display("FAIL arst_repush got=%b %h_%h exp=1 00000500_%h", log_valid, log_addr, log_data, d);
    end
  endtask

  initial begin
    test_reset();
    test_ram_store();
    test_fifo_overflow();
    test_full_pop_push();
    test_misaligned();
    test_done();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder on the far side of the processor's store/load data port (`address`, `write_data`, `mem_write`). It serves word loads combinationally and commits word stores to a local RAM. It diverts stores in an MMIO window into a small log FIFO that drains over a valid/ready handshake. It also raises a sticky `done` when the self-check store (address 108, data `32'hABCDE7D5`) is observed.

## Interface
- `DEPTH_WORDS`, default 64: RAM words (power of two).
- `MMIO_BASE`, default `32'h0000_0400`: first byte address of the MMIO window; window extends to `32'hFFFF_FFFF`.
- `FIFO_DEPTH`, default 4: log FIFO entries (power of two, ≥2).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, asynchronous, active-low.
- `mem_write` in 1: store strobe from processor.
- `address` in 32: byte address for load or store.
- `write_data` in 32: store data.
- `read_data` out 32: load data, combinational from `address`.
- `log_valid` out 1: FIFO head valid.
- `log_ready` in 1: consumer accepts head.
- `log_addr` out 32: head entry address.
- `log_data` out 32: head entry data.
- `log_overflow` out 1: sticky, an MMIO store was dropped because the FIFO was full.
- `misaligned` out 1: sticky, a store with `address[1:0] != 0` was seen.
- `done` out 1: sticky, self-check store seen.

## Operation
- Store classes on a rising edge with `mem_write=1`:
  - Misaligned: dropped and `misaligned` set.
  - Aligned with `address < MMIO_BASE`: RAM store. Word index is `address[$clog2(DEPTH_WORDS)+1:2]`, so addresses above the RAM alias by wrap.
  - Aligned with `address >= MMIO_BASE`: log push of `{address, write_data}`.
- Loads:
  - `read_data` is the RAM word at the index when `address < MMIO_BASE`.
  - `read_data` is `32'h0` in the MMIO window.
  - The low address bits are ignored for loads.
- FIFO push and pop:
  - Pop when `log_valid && log_ready`.
  - Push when full with a simultaneous pop: accepted.
  - Push when full without a pop: dropped and `log_overflow` set. Existing entries are unchanged.
- `log_addr` and `log_data` hold their value while `log_valid && !log_ready`. They are don't-care when `log_valid=0`.
- `done` is set by any store with `address==108` and `write_data==32'hABCDE7D5`, independent of region. It clears only on reset.
- Reset values:
  - `log_valid`, `log_overflow`, `misaligned` and `done` are 0.
  - FIFO pointers and count are 0.
  - RAM contents are not reset.
- Reset mid-operation discards all FIFO entries, including a head that is being offered.

## Timing
- Load latency is 0 cycles (combinational), as the single-cycle core requires.
- A RAM store is visible on `read_data` after the storing edge. A load to the same word in the storing cycle returns the old value.
- Push into an empty FIFO: `log_valid` rises 1 cycle after the storing edge. There is no bypass.
- Throughput is 1 push and 1 pop per cycle. Count is unchanged on a simultaneous push and pop.
- Sticky flags assert on the edge that samples the causing store.
- The FIFO has `FIFO_DEPTH` entries and `$clog2(FIFO_DEPTH)` pointer bits with wrap-around. A separate count of `$clog2(FIFO_DEPTH)+1` bits distinguishes full from empty.

## Configuration
- `DMEM_PASS_DETECT_EN`:
  - Defined: the `done` comparator and flag are present as described.
  - Undefined: `done` is tied to 0 and no comparator logic is synthesized. All other behaviour is identical.

## Structure
- Package `dmem_pkg`:
  - `log_entry_t` packed struct `{logic [31:0] addr; logic [31:0] data;}`.
  - Constants `PASS_ADDR=32'd108`, `PASS_DATA=32'hABCDE7D5`, `DEFAULT_MMIO_BASE`.
- Sub-module `store_log_fifo`: parameterized on `FIFO_DEPTH` over `log_entry_t`. It carries push/full/pop/empty and an overflow pulse.
- RAM, address decode, sticky flags and pass detect stay in `dmem_responder`.

## Test plan
- Store `32'h1234_5678` to address 8, then load address 8 → `read_data==32'h1234_5678` the next cycle. Same-cycle load → previous contents.
- `log_ready=0`, then 5 stores to `0x400`..`0x410` → `log_valid=1`, head `{0x400, data0}`, `log_overflow=1`, FIFO holds the first 4. Then `log_ready=1` → 4 pops in order, then `log_valid=0`.
- FIFO full with `log_ready=1` and a store to `0x420` in the same cycle → no overflow, count stays 4, and the `0x420` entry arrives last.
- Store to address 6 → RAM unchanged and `misaligned=1`. Load from `0x404` → `read_data==0`.
- Store `32'hABCDE7D5` to 108 → `done=1` the next cycle with the macro defined, and 0 without it. Store `32'hABCDE7D4` to 108 → `done` unchanged.
- Assert `rst=0` asynchronously mid-drain with 3 entries → `log_valid`, `log_overflow`, `misaligned` and `done` go to 0 immediately. After release, the FIFO is empty.
